// File: rtl/ic_hc_byte_stuffing.sv
// rtl/ic_hc_byte_stuffing.sv - JPEG byte stuffer: 0xFF->0xFF00, EOI append, 32-bit repack, byte count
module ic_hc_byte_stuffing #(
   parameter logic [7:0] PAD_BYTE     = 8'h00,
   parameter bit         STUFF_ENABLE = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        BS_inputready,
   input  logic [31:0] BS_readdata,
   input  logic        BS_EndOfImage,
   output logic        BS_wait_request,
   output logic        BS_outputready,
   output logic [31:0] BS_writedata,
   output logic [31:0] BS_ByteCount,
   output logic        BS_Done,
   output logic        BS_overflow
);

   typedef enum logic [2:0] {
      S_IDLE, S_BYTE, S_STUFF, S_EOI_FF, S_EOI_D9, S_PAD, S_DONE
   } state_t;

   state_t      r_state, w_next;
   logic [31:0] r_hold;
   logic [2:0]  r_idx;
   logic        r_eoi;
   logic        r_wait;
   logic        r_ovf;
   logic        r_done;
   logic        r_outready;
   logic [31:0] r_wdata;
   logic [31:0] r_pack;
   logic [1:0]  r_cnt;
   logic [31:0] r_count;

   logic        w_accept;
   logic        w_eoi;
   logic [7:0]  w_cur_byte;
   logic        w_wr;
   logic [7:0]  w_wr_byte;
   logic        w_pad;
   logic [31:0] w_pack_wr;

   assign w_accept = BS_inputready && !r_wait && (r_state == S_IDLE);
   // A pulse arriving this cycle already counts for the exit decision of the current byte.
   assign w_eoi    = r_eoi || BS_EndOfImage;

   always_comb begin
      w_cur_byte = r_hold[31:24];
      case (r_idx[1:0])
         2'd0:    w_cur_byte = r_hold[31:24];
         2'd1:    w_cur_byte = r_hold[23:16];
         2'd2:    w_cur_byte = r_hold[15:8];
         default: w_cur_byte = r_hold[7:0];
      endcase
   end

   always_comb begin
      w_next    = r_state;
      w_wr      = 1'b0;
      w_wr_byte = 8'h00;
      w_pad     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept)   w_next = S_BYTE;
            else if (w_eoi) w_next = S_EOI_FF;
         end
         S_BYTE: begin
            w_wr      = 1'b1;
            w_wr_byte = w_cur_byte;
            if (STUFF_ENABLE && (w_cur_byte == 8'hFF)) w_next = S_STUFF;
            else if (r_idx != 3'd3)                     w_next = S_BYTE;
            else                                        w_next = w_eoi ? S_EOI_FF : S_IDLE;
         end
         S_STUFF: begin
            // r_idx already points past the stuffed byte here
            w_wr      = 1'b1;
            w_wr_byte = 8'h00;
            if (r_idx != 3'd4) w_next = S_BYTE;
            else               w_next = w_eoi ? S_EOI_FF : S_IDLE;
         end
         S_EOI_FF: begin
            w_wr      = 1'b1;
            w_wr_byte = 8'hFF;
            w_next    = S_EOI_D9;
         end
         S_EOI_D9: begin
            w_wr      = 1'b1;
            w_wr_byte = 8'hD9;
            w_next    = S_PAD;
         end
         S_PAD: begin
            w_pad  = (r_cnt != 2'd0);
            w_next = S_DONE;
         end
         S_DONE:  w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_pack_wr = r_pack;
      case (r_cnt)
         2'd0:    w_pack_wr[31:24] = w_wr_byte;
         2'd1:    w_pack_wr[23:16] = w_wr_byte;
         2'd2:    w_pack_wr[15:8]  = w_wr_byte;
         default: w_pack_wr[7:0]   = w_wr_byte;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_hold  <= 32'h0;
         r_idx   <= 3'd0;
         r_eoi   <= 1'b0;
         r_wait  <= 1'b0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_hold <= BS_readdata;
            r_idx  <= 3'd0;
         end else if (r_state == S_BYTE) begin
            r_idx <= r_idx + 3'd1;
         end
         r_eoi  <= w_eoi;
         r_wait <= (w_next != S_IDLE) || w_eoi;
         r_ovf  <= r_ovf || (BS_inputready && r_wait);
         r_done <= (w_next == S_DONE);
      end
   end

   // Unused lanes are preloaded with PAD_BYTE so a pad flush is just the packer contents.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pack     <= {4{PAD_BYTE}};
         r_cnt      <= 2'd0;
         r_count    <= 32'h0;
         r_wdata    <= 32'h0;
         r_outready <= 1'b0;
      end else begin
         r_outready <= 1'b0;
         if (w_wr) begin
            r_cnt   <= r_cnt + 2'd1;
            r_count <= r_count + 32'd1;
            if (r_cnt == 2'd3) begin
               r_wdata    <= w_pack_wr;
               r_outready <= 1'b1;
               r_pack     <= {4{PAD_BYTE}};
            end else begin
               r_pack <= w_pack_wr;
            end
         end else if (w_pad) begin
            r_wdata    <= r_pack;
            r_outready <= 1'b1;
            r_pack     <= {4{PAD_BYTE}};
            r_cnt      <= 2'd0;
         end
      end
   end

   assign BS_wait_request = r_wait;
   assign BS_outputready  = r_outready;
   assign BS_writedata    = r_wdata;
   assign BS_ByteCount    = r_count;
   assign BS_Done         = r_done;
   assign BS_overflow     = r_ovf;

endmodule

// File: tb/tb_ic_hc_byte_stuffing.sv
// tb/tb_ic_hc_byte_stuffing.sv - directed bench with byte-stream model, stuffing on and off
module tb_ic_hc_byte_stuffing;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        inr;
   logic [31:0] rdata;
   logic        eoi;

   logic        wait_a, ordy_a, done_a, ovf_a;
   logic [31:0] wdata_a, cnt_a;
   logic        wait_b, ordy_b, done_b, ovf_b;
   logic [31:0] wdata_b, cnt_b;

   always #5 clk = ~clk;

   ic_hc_byte_stuffing #(.PAD_BYTE(8'h00), .STUFF_ENABLE(1'b1)) u_a (
      .clk(clk), .reset_n(reset_n), .BS_inputready(inr), .BS_readdata(rdata),
      .BS_EndOfImage(eoi), .BS_wait_request(wait_a), .BS_outputready(ordy_a),
      .BS_writedata(wdata_a), .BS_ByteCount(cnt_a), .BS_Done(done_a), .BS_overflow(ovf_a)
   );

   ic_hc_byte_stuffing #(.PAD_BYTE(8'h00), .STUFF_ENABLE(1'b0)) u_b (
      .clk(clk), .reset_n(reset_n), .BS_inputready(inr), .BS_readdata(rdata),
      .BS_EndOfImage(eoi), .BS_wait_request(wait_b), .BS_outputready(ordy_b),
      .BS_writedata(wdata_b), .BS_ByteCount(cnt_b), .BS_Done(done_b), .BS_overflow(ovf_b)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] wq0[$], wq1[$], log0[$], log1[$];
   logic [31:0] part_w[2];
   int          part_n[2];
   int          mcnt[2];
   logic        movf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: instance 0 stuffs, instance 1 does not; words form from a flat byte stream.
   task automatic m_byte(input int i, input logic [7:0] b, input bit counted);
      part_w[i] = part_w[i] | (32'(b) << (24 - 8 * part_n[i]));
      part_n[i]++;
      if (counted) mcnt[i]++;
      if (part_n[i] == 4) begin
         if (i == 0) begin wq0.push_back(part_w[i]); log0.push_back(part_w[i]); end
         else        begin wq1.push_back(part_w[i]); log1.push_back(part_w[i]); end
         part_w[i] = 32'h0;
         part_n[i] = 0;
      end
   endtask

   task automatic m_word(input logic [31:0] w);
      logic [7:0] b;
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 4; k++) begin
            b = 8'(w >> (24 - 8 * k));
            m_byte(i, b, 1'b1);
            if (i == 0 && b == 8'hFF) m_byte(i, 8'h00, 1'b1);
         end
      end
   endtask

   task automatic m_eoi();
      for (int i = 0; i < 2; i++) begin
         m_byte(i, 8'hFF, 1'b1);
         m_byte(i, 8'hD9, 1'b1);
         while (part_n[i] != 0) m_byte(i, 8'h00, 1'b0);
      end
   endtask

   task automatic m_clear();
      wq0.delete(); wq1.delete(); log0.delete(); log1.delete();
      for (int i = 0; i < 2; i++) begin
         part_w[i] = 32'h0; part_n[i] = 0; mcnt[i] = 0;
      end
      movf = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         check("rst_ordy_a", {31'h0, ordy_a}, 32'h0);
         check("rst_ordy_b", {31'h0, ordy_b}, 32'h0);
      end else begin
         if (ordy_a) begin
            if (wq0.size() == 0) check("extra_word_a", wdata_a, 32'hxxxxxxxx);
            else                 check("word_a", wdata_a, wq0.pop_front());
         end
         if (ordy_b) begin
            if (wq1.size() == 0) check("extra_word_b", wdata_b, 32'hxxxxxxxx);
            else                 check("word_b", wdata_b, wq1.pop_front());
         end
         check("ovf_a", {31'h0, ovf_a}, {31'h0, movf});
         check("ovf_b", {31'h0, ovf_b}, {31'h0, movf});
      end
   end

   task automatic do_reset();
      reset_n = 1'b0;
      inr = 1'b0; eoi = 1'b0; rdata = 32'h0;
      m_clear();
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_wait_a"}, {31'h0, wait_a}, 32'h0);
      check({tag, "_ordy_a"}, {31'h0, ordy_a}, 32'h0);
      check({tag, "_wdata_a"}, wdata_a, 32'h0);
      check({tag, "_cnt_a"}, cnt_a, 32'h0);
      check({tag, "_done_a"}, {31'h0, done_a}, 32'h0);
      check({tag, "_ovf_a"}, {31'h0, ovf_a}, 32'h0);
      check({tag, "_cnt_b"}, cnt_b, 32'h0);
      check({tag, "_wait_b"}, {31'h0, wait_b}, 32'h0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((wait_a !== 1'b0 || wait_b !== 1'b0) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 100) check("idle_timeout", 32'h1, 32'h0);
   endtask

   task automatic drain();
      int n = 0;
      while ((wq0.size() != 0 || wq1.size() != 0) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 100) check("drain_timeout", 32'h1, 32'h0);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!(done_a === 1'b1 && done_b === 1'b1) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check("done_a", {31'h0, done_a}, 32'h1);
      check("done_b", {31'h0, done_b}, 32'h1);
   endtask

   task automatic send(input logic [31:0] w, input bit with_eoi);
      wait_idle();
      inr = 1'b1; rdata = w; eoi = with_eoi;
      @(posedge clk); #1;
      inr = 1'b0; eoi = 1'b0;
      m_word(w);
      if (with_eoi) m_eoi();
   endtask

   task automatic strobe_drop(input logic [31:0] w);
      inr = 1'b1; rdata = w;
      @(posedge clk); #1;
      inr = 1'b0;
      movf = 1'b1;
   endtask

   task automatic pulse_eoi();
      eoi = 1'b1;
      @(posedge clk); #1;
      eoi = 1'b0;
      m_eoi();
   endtask

   task automatic check_counts(input string tag, input logic [31:0] ea, input logic [31:0] eb);
      check({tag, "_cnt_a"}, cnt_a, ea);
      check({tag, "_cnt_b"}, cnt_b, eb);
      check({tag, "_model_cnt_a"}, 32'(mcnt[0]), ea);
      check({tag, "_model_cnt_b"}, 32'(mcnt[1]), eb);
   endtask

   initial begin
      reset_n = 1'b0; inr = 1'b0; eoi = 1'b0; rdata = 32'h0;
      m_clear();
      #1 check_zero("reset");
      do_reset();
      check_zero("release");

      // single word, latency and wait_request window
      send(32'h12345678, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("t1_wait_t%0d", k), {31'h0, wait_a}, 32'h1);
         check($sformatf("t1_ordy_t%0d", k), {31'h0, ordy_a}, 32'h0);
         @(posedge clk); #1;
      end
      check("t1_ordy_t5", {31'h0, ordy_a}, 32'h1);
      check("t1_wdata_t5", wdata_a, 32'h12345678);
      check("t1_wait_t5", {31'h0, wait_a}, 32'h0);
      drain();
      check_counts("t1", 32'd4, 32'd4);

      // stuffing across word boundary, partial word left in packer
      do_reset();
      send(32'hFF00FF11, 1'b0);
      send(32'hAABBCCDD, 1'b0);
      wait_idle();
      drain();
      check("t2_log_a_n", 32'(log0.size()), 32'd2);
      check("t2_log_a0", log0[0], 32'hFF0000FF);
      check("t2_log_a1", log0[1], 32'h0011AABB);
      check("t2_log_b1", log1[1], 32'hAABBCCDD);
      check_counts("t2", 32'd10, 32'd8);

      // word then separate EOI pulse while busy
      do_reset();
      send(32'hABCDEF01, 1'b0);
      pulse_eoi();
      wait_done();
      drain();
      check("t3_log_a1", log0[1], 32'hFFD90000);
      check("t3_wait_a", {31'h0, wait_a}, 32'h1);
      check_counts("t3", 32'd6, 32'd6);

      // all-0xFF word with EOI coincident with accept
      do_reset();
      send(32'hFFFFFFFF, 1'b1);
      wait_done();
      drain();
      check("t4_log_a_n", 32'(log0.size()), 32'd3);
      check("t4_log_a0", log0[0], 32'hFF00FF00);
      check("t4_log_a2", log0[2], 32'hFFD90000);
      check("t4_log_b0", log1[0], 32'hFFFFFFFF);
      check_counts("t4", 32'd10, 32'd6);

      // EOI lands exactly on a word boundary: no pad word for the stuffing instance
      do_reset();
      send(32'hFF00FF11, 1'b0);
      pulse_eoi();
      wait_done();
      drain();
      check("t4b_log_a_n", 32'(log0.size()), 32'd2);
      check("t4b_log_a1", log0[1], 32'h0011FFD9);
      check_counts("t4b", 32'd8, 32'd6);

      // dropped word sets sticky overflow
      do_reset();
      send(32'h22222222, 1'b0);
      strobe_drop(32'h11111111);
      wait_idle();
      check("t5_ovf_hold", {31'h0, ovf_a}, 32'h1);
      pulse_eoi();
      wait_done();
      drain();
      check("t5_log_a0", log0[0], 32'h22222222);
      check("t5_ovf_end", {31'h0, ovf_a}, 32'h1);
      check_counts("t5", 32'd6, 32'd6);

      // EOI with no data
      do_reset();
      pulse_eoi();
      wait_done();
      drain();
      check("t5b_log_a_n", 32'(log0.size()), 32'd1);
      check("t5b_log_a0", log0[0], 32'hFFD90000);
      check_counts("t5b", 32'd2, 32'd2);

      // reset mid-word, then clean word
      do_reset();
      send(32'hAABBCCDD, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t6_cnt_before", cnt_a, 32'd2);
      reset_n = 1'b0;
      m_clear();
      #1 check_zero("t6_async");
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk); #1;
      check_zero("t6_release");
      send(32'h01020304, 1'b0);
      wait_idle();
      drain();
      repeat (3) @(posedge clk);
      #1;
      check("t6_log_a_n", 32'(log0.size()), 32'd1);
      check("t6_log_a0", log0[0], 32'h01020304);
      check_counts("t6", 32'd4, 32'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ic_hc_byte_stuffing.md
Name: ic_hc_byte_stuffing

Overview:
- Sits directly downstream of the Huffman coding stage. Consumes its 32-bit packed entropy-coded words and produces the JPEG-compliant scan stream.
- Inserts a 0x00 after every 0xFF data byte. On end of image it appends the EOI marker (0xFF 0xD9) and pads the final word.
- Re-packs the result into 32-bit words for the output memory writer.
- Counts the exact number of valid output bytes.

Parameters:
- PAD_BYTE, 8'h00, value used to fill unused byte lanes of the final output word.
- STUFF_ENABLE, 1, 1 = insert 0x00 after each 0xFF data byte; 0 = pass bytes unmodified (EOI still appended).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset (~reset_n && IC_global_enable at top level)
- BS_inputready  input  1  one-cycle valid strobe for BS_readdata
- BS_readdata  input  32  packed Huffman word; byte order [31:24] first
- BS_EndOfImage  input  1  one-cycle pulse; no further input words follow
- BS_wait_request  output  1  high = input word will not be accepted
- BS_outputready  output  1  one-cycle strobe for BS_writedata
- BS_writedata  output  32  stuffed output word; [31:24] first byte
- BS_ByteCount  output  32  running count of valid output bytes, including stuffed bytes and EOI
- BS_Done  output  1  level; high once the final word has been emitted
- BS_overflow  output  1  sticky; input strobed while BS_wait_request was high

Behaviour:
- Reset (async, reset_n=0): all outputs 0, holding register empty, packer empty, EOI latch clear, FSM=IDLE. Reset mid-operation discards all data in flight; no output strobe occurs during or on the release of reset.
- Accept rule: a word is accepted when BS_inputready=1 and BS_wait_request=0. It is loaded into a 4-byte holding register. If BS_inputready=1 while BS_wait_request=1, the word is dropped, BS_overflow is set, and state is otherwise unchanged.
- BS_wait_request is registered. It is high from the cycle after an accept until the cycle after the last byte of that word has been processed. It is also high permanently once EOI has been latched.
- FSM states: IDLE, BYTE, STUFF, EOI_FF, EOI_D9, PAD, DONE.
- IDLE -> BYTE on accept.
- BYTE: one byte per cycle into the packer, MSB lane first.
  - If the byte is 0xFF and STUFF_ENABLE=1 -> STUFF.
  - Else, if more bytes remain in the holding register -> BYTE.
  - Else -> IDLE, or -> EOI_FF if EOI is latched.
- STUFF: writes 0x00 into the packer (one cycle), then continues as BYTE would after its byte.
- EOI_FF writes 0xFF; EOI_D9 writes 0xD9.
- PAD: fills the remaining lanes with PAD_BYTE in a single cycle, only if the packer is non-empty. Then -> DONE.
- DONE: BS_Done=1 and BS_wait_request=1 until reset.
- EOI latch:
  - BS_EndOfImage sets the latch in any state.
  - If the pulse coincides with an accept, the word is processed first.
  - If EOI arrives while in IDLE with an empty holding register -> EOI_FF next cycle.
- Packer:
  - 2-bit lane counter. Each written byte goes to lane 3−cnt, and BS_ByteCount increments by 1.
  - When the 4th lane is written, or PAD completes, BS_writedata is registered and BS_outputready is pulsed in the next cycle, and the packer clears.
  - PAD lanes do not increment BS_ByteCount.
  - The packer never holds more than 3 bytes across an output strobe; the lane counter wraps 3 -> 0.
- Latency: an accepted word with no 0xFF fills its 4 bytes on cycles t+1..t+4. If the packer started empty, BS_outputready is asserted at t+5.
- Downstream has no backpressure; BS_outputready is never suppressed.
- BS_ByteCount holds its final value after DONE. It wraps modulo 2^32 (not reached in practice).

Test Plan:
1. Accept 0x12345678 with the packer empty -> BS_outputready at t+5 with 0x12345678; BS_ByteCount=4; BS_wait_request high for cycles t+1..t+4.
2. Words 0xFF00FF11 then 0xAABBCCDD -> outputs 0xFF0000FF, 0x0011AABB; BS_ByteCount=10 with bytes CC DD held in the packer.
3. Word 0xABCDEF01, then BS_EndOfImage pulse -> outputs 0xABCDEF01, 0xFFD90000; BS_ByteCount=6; BS_Done=1 after the second strobe.
4. Word 0xFFFFFFFF then EOI -> outputs 0xFF00FF00, 0xFF00FF00, 0xFFD90000; BS_ByteCount=10. With STUFF_ENABLE=0 -> 0xFFFFFFFF, 0xFFD90000; count 6.
5. Strobe BS_inputready with 0x11111111 while BS_wait_request=1 -> word absent from the output, BS_overflow=1 and stays 1. EOI alone with no data -> single output 0xFFD90000, BS_ByteCount=2.
6. Assert reset_n=0 mid-word (two bytes packed) -> all outputs 0 immediately. After release, word 0x01020304 -> output 0x01020304, BS_ByteCount=4, with no stale bytes.
